cdb_arbiter: RTL and testbench

- Shares one common data bus (CDB) between the ALU and LSB result producers, so the ROB, RS and LSB snoop a single result port.
- Each source has a small FIFO, and at most one result is broadcast per cycle.
- Contention is resolved round-robin.
- An empty FIFO is bypassed, giving 1-cycle latency.
- The whole block flushes on ROB rollback.

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 99 +++++++++
 tb/tb_cdb_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer-side and broadcast-side signals of the CDB arbiter
interface cdb_arbiter_if;
  logic        alu_valid;
  logic [3:0]  alu_rob_pos;
  logic [31:0] alu_val;
  logic        alu_jump;
  logic [31:0] alu_pc;
  logic        alu_full;
  logic        lsb_valid;
  logic [3:0]  lsb_rob_pos;
  logic [31:0] lsb_val;
  logic        lsb_full;
  logic        cdb_valid;
  logic        cdb_src;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;
  logic        cdb_jump;
  logic [31:0] cdb_pc;
  modport master (
    output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
    output lsb_valid, lsb_rob_pos, lsb_val,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
  );
  modport slave (
    input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
    input  lsb_valid, lsb_rob_pos, lsb_val,
    output alu_full, lsb_full,
    output cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of one result bus between ALU and LSB FIFOs with empty-FIFO bypass
module cdb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rollback,
  cdb_arbiter_if.slave bus
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  logic [3:0]        r_alu_rob [DEPTH];
  logic [31:0]       r_alu_val [DEPTH];
  logic              r_alu_jump [DEPTH];
  logic [31:0]       r_alu_pc [DEPTH];
  logic [3:0]        r_lsb_rob [DEPTH];
  logic [31:0]       r_lsb_val [DEPTH];
  logic [ADDR_W-1:0] r_alu_rp, r_alu_wp, r_lsb_rp, r_lsb_wp;
  logic [ADDR_W:0]   r_alu_cnt, r_lsb_cnt;
  logic              r_prio;
  logic              r_cdb_valid, r_cdb_src, r_cdb_jump;
  logic [3:0]        r_cdb_rob;
  logic [31:0]       r_cdb_val, r_cdb_pc;
  logic              w_run, w_alu_empty, w_lsb_empty, w_cand_alu, w_cand_lsb;
  logic              w_gnt_alu, w_gnt_lsb, w_alu_pop, w_lsb_pop, w_alu_push, w_lsb_push;
  always_comb begin
    w_run       = rdy && !rst && !rollback;
    w_alu_empty = r_alu_cnt == '0;
    w_lsb_empty = r_lsb_cnt == '0;
    w_cand_alu  = !w_alu_empty || bus.alu_valid;
    w_cand_lsb  = !w_lsb_empty || bus.lsb_valid;
    w_gnt_alu   = w_cand_alu && (!w_cand_lsb || !r_prio);
    w_gnt_lsb   = w_cand_lsb && !w_gnt_alu;
    w_alu_pop   = w_gnt_alu && !w_alu_empty;
    w_lsb_pop   = w_gnt_lsb && !w_lsb_empty;
    w_alu_push  = bus.alu_valid && r_alu_cnt != FULL && !(w_gnt_alu && w_alu_empty);
    w_lsb_push  = bus.lsb_valid && r_lsb_cnt != FULL && !(w_gnt_lsb && w_lsb_empty);
  end
  always_ff @(posedge clk) begin
    if (w_run && w_alu_push) begin
      r_alu_rob[r_alu_wp]  <= bus.alu_rob_pos;
      r_alu_val[r_alu_wp]  <= bus.alu_val;
      r_alu_jump[r_alu_wp] <= bus.alu_jump;
      r_alu_pc[r_alu_wp]   <= bus.alu_pc;
    end
    if (w_run && w_lsb_push) begin
      r_lsb_rob[r_lsb_wp] <= bus.lsb_rob_pos;
      r_lsb_val[r_lsb_wp] <= bus.lsb_val;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      r_alu_rp    <= '0;
      r_alu_wp    <= '0;
      r_lsb_rp    <= '0;
      r_lsb_wp    <= '0;
      r_alu_cnt   <= '0;
      r_lsb_cnt   <= '0;
      r_prio      <= 1'b0;
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= 1'b0;
      r_cdb_rob   <= '0;
      r_cdb_val   <= '0;
      r_cdb_jump  <= 1'b0;
      r_cdb_pc    <= '0;
    end else if (rdy) begin
      r_alu_rp    <= r_alu_rp + ADDR_W'(w_alu_pop);
      r_alu_wp    <= r_alu_wp + ADDR_W'(w_alu_push);
      r_lsb_rp    <= r_lsb_rp + ADDR_W'(w_lsb_pop);
      r_lsb_wp    <= r_lsb_wp + ADDR_W'(w_lsb_push);
      r_alu_cnt   <= r_alu_cnt + (ADDR_W+1)'(w_alu_push) - (ADDR_W+1)'(w_alu_pop);
      r_lsb_cnt   <= r_lsb_cnt + (ADDR_W+1)'(w_lsb_push) - (ADDR_W+1)'(w_lsb_pop);
      r_prio      <= w_gnt_alu ? 1'b1 : w_gnt_lsb ? 1'b0 : r_prio;
      r_cdb_valid <= w_gnt_alu || w_gnt_lsb;
      if (w_gnt_alu) begin
        r_cdb_src  <= 1'b0;
        r_cdb_rob  <= w_alu_empty ? bus.alu_rob_pos : r_alu_rob[r_alu_rp];
        r_cdb_val  <= w_alu_empty ? bus.alu_val : r_alu_val[r_alu_rp];
        r_cdb_jump <= w_alu_empty ? bus.alu_jump : r_alu_jump[r_alu_rp];
        r_cdb_pc   <= w_alu_empty ? bus.alu_pc : r_alu_pc[r_alu_rp];
      end else if (w_gnt_lsb) begin
        r_cdb_src  <= 1'b1;
        r_cdb_rob  <= w_lsb_empty ? bus.lsb_rob_pos : r_lsb_rob[r_lsb_rp];
        r_cdb_val  <= w_lsb_empty ? bus.lsb_val : r_lsb_val[r_lsb_rp];
        r_cdb_jump <= 1'b0;
        r_cdb_pc   <= '0;
      end
    end
  end
  assign bus.alu_full    = r_alu_cnt == FULL;
  assign bus.lsb_full    = r_lsb_cnt == FULL;
  assign bus.cdb_valid   = r_cdb_valid;
  assign bus.cdb_src     = r_cdb_src;
  assign bus.cdb_rob_pos = r_cdb_rob;
  assign bus.cdb_val     = r_cdb_val;
  assign bus.cdb_jump    = r_cdb_jump;
  assign bus.cdb_pc      = r_cdb_pc;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for the CDB arbiter
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  cdb_arbiter_if bus();
  cdb_arbiter #(.DEPTH(4), .ADDR_W(2)) dut (.clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [68:0] aq[$];
  logic [68:0] lq[$];
  logic live = 1'b0;
  logic alt_on = 1'b0;
  logic prev_src = 1'b0;
  logic seen_first = 1'b0;
  logic lsb_seen;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) live <= rdy && !rst && !rollback;
  always @(negedge clk) begin
    if (live && bus.cdb_valid) begin
      if (bus.cdb_src) begin
        if (lq.size() == 0) check("lsb_unexpected", 1, 0);
        else check("lsb_data", {bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc}, lq.pop_front());
      end else begin
        if (aq.size() == 0) check("alu_unexpected", 1, 0);
        else check("alu_data", {bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc}, aq.pop_front());
      end
      if (alt_on && seen_first) check("alternate", bus.cdb_src, !prev_src);
      prev_src <= bus.cdb_src;
      seen_first <= alt_on;
    end
  end
  task automatic cyc();
    @(posedge clk);
    if (rst || rollback) begin
      aq.delete();
      lq.delete();
    end else if (rdy) begin
      if (bus.alu_valid) aq.push_back({bus.alu_rob_pos, bus.alu_val, bus.alu_jump, bus.alu_pc});
      if (bus.lsb_valid) lq.push_back({bus.lsb_rob_pos, bus.lsb_val, 1'b0, 32'h0});
    end
    #1;
  endtask
  task automatic set_alu(input logic v, input logic [3:0] p, input logic [31:0] d, input logic j, input logic [31:0] pc);
    bus.alu_valid = v;
    bus.alu_rob_pos = p;
    bus.alu_val = d;
    bus.alu_jump = j;
    bus.alu_pc = pc;
  endtask
  task automatic set_lsb(input logic v, input logic [3:0] p, input logic [31:0] d);
    bus.lsb_valid = v;
    bus.lsb_rob_pos = p;
    bus.lsb_val = d;
  endtask
  task automatic idle();
    set_alu(0, 0, 0, 0, 0);
    set_lsb(0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (aq.size() + lq.size()) != 0; i++) cyc();
    cyc();
    check(tag, 32'(aq.size() + lq.size()), 0);
  endtask
  initial begin
    do_reset();
    check("rst_cdb", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc}, 0);
    check("rst_full", {bus.alu_full, bus.lsb_full}, 0);
    set_alu(1, 3, 32'h11, 1, 32'h100);
    cyc();
    idle();
    check("byp_payload", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc},
          {1'b1, 1'b0, 4'd3, 32'h11, 1'b1, 32'h100});
    cyc();
    check("byp_idle", bus.cdb_valid, 0);
    do_reset();
    set_alu(1, 1, 32'hA, 0, 32'h40);
    set_lsb(1, 2, 32'hB);
    cyc();
    check("ct_first", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos}, {1'b1, 1'b0, 4'd1});
    set_alu(1, 4, 32'hC, 1, 32'h80);
    set_lsb(1, 5, 32'hD);
    cyc();
    idle();
    check("ct_second", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos}, {1'b1, 1'b1, 4'd2});
    cyc();
    check("ct_third", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos}, {1'b1, 1'b0, 4'd4});
    cyc();
    check("ct_fourth", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos}, {1'b1, 1'b1, 4'd5});
    cyc();
    check("ct_idle", bus.cdb_valid, 0);
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_alu(1, 4'(i), 32'h100 + 32'(i), 0, 0);
      set_lsb(1, 4'(i), 32'h200 + 32'(i));
      cyc();
    end
    set_alu(0, 0, 0, 0, 0);
    set_lsb(1, 4, 32'h204);
    cyc();
    idle();
    check("pp_pop", {bus.cdb_valid, bus.cdb_src, bus.cdb_val}, {1'b1, 1'b1, 32'h202});
    cyc();
    check("pp_alu", {bus.cdb_valid, bus.cdb_src, bus.cdb_val}, {1'b1, 1'b0, 32'h103});
    cyc();
    check("pp_lsb3", {bus.cdb_valid, bus.cdb_src, bus.cdb_val}, {1'b1, 1'b1, 32'h203});
    cyc();
    check("pp_lsb4", {bus.cdb_valid, bus.cdb_src, bus.cdb_val}, {1'b1, 1'b1, 32'h204});
    cyc();
    check("pp_idle", bus.cdb_valid, 0);
    do_reset();
    lsb_seen = 1'b0;
    alt_on = 1'b1;
    for (int i = 0, nl = 0; i < 14; i++) begin
      if (i == 6) check("fill_not_full", bus.lsb_full, 0);
      if (i == 7) check("fill_full", bus.lsb_full, 1);
      if (bus.lsb_full) lsb_seen = 1'b1;
      set_alu(!bus.alu_full, 4'(i), 32'h300 + 32'(i), i[0], 32'h1000 + 32'(i));
      set_lsb(!bus.lsb_full && nl < 10, 4'(i), 32'h400 + 32'(nl));
      if (bus.lsb_valid) nl++;
      cyc();
    end
    alt_on = 1'b0;
    idle();
    check("fill_seen", lsb_seen, 1);
    drain("fill_drain");
    check("fill_flags", {bus.alu_full, bus.lsb_full}, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alu(1, 4'(i), 32'h500 + 32'(i), 0, 32'h2000);
      set_lsb(1, 4'(i), 32'h600 + 32'(i));
      cyc();
    end
    set_alu(0, 0, 0, 0, 0);
    set_lsb(1, 9, 32'h699);
    rollback = 1'b1;
    cyc();
    rollback = 1'b0;
    idle();
    check("rb_valid", bus.cdb_valid, 0);
    check("rb_full", {bus.alu_full, bus.lsb_full}, 0);
    cyc();
    check("rb_empty", bus.cdb_valid, 0);
    set_alu(1, 7, 32'h77, 0, 32'h10);
    set_lsb(1, 8, 32'h88);
    cyc();
    idle();
    check("rb_prio", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos}, {1'b1, 1'b0, 4'd7});
    cyc();
    set_alu(1, 6, 32'h66, 1, 32'h20);
    cyc();
    idle();
    check("rb_bypass", {bus.cdb_valid, bus.cdb_src, bus.cdb_val}, {1'b1, 1'b0, 32'h66});
    set_alu(1, 2, 32'hF0, 0, 32'h30);
    cyc();
    idle();
    check("frz_pre", {bus.cdb_valid, bus.cdb_val}, {1'b1, 32'hF0});
    rdy = 1'b0;
    set_alu(1, 3, 32'hF1, 1, 32'h34);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("frz_hold", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_pc}, {1'b1, 1'b0, 4'd2, 32'hF0, 32'h30});
    end
    rdy = 1'b1;
    cyc();
    idle();
    check("frz_resume", {bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump}, {1'b1, 4'd3, 32'hF1, 1'b1});
    cyc();
    check("frz_idle", bus.cdb_valid, 0);
    drain("final_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
